bus_decoder_n: RTL and testbench
================================

# bus_decoder_n

Parametrised, registered address decoder and read-data multiplexer between the 68000 master bus and NUM_SLAVES peripheral slaves. It latches the slave selection at the start of each bus cycle. It holds the acknowledge and read data until the master drops `as`, and it generates bus error on decode misses and on slave timeouts. It records the address of the last error for software diagnosis and sits directly between the CPU core wrapper and the RAM, UART, LED, SPI, timer and interrupt-controller slaves.

## Interface
- `NUM_SLAVES`, 6: number of slave ports, 1..16.
- `SLAVE_BASE`, {32'h100400, 32'h100300, 32'h100200, 32'h100100, 32'h100000, 32'h000000}: packed NUM_SLAVES×32 bits; slice i is the base of slave i.
- `SLAVE_MASK`, {5{32'hFFFF_FF00}}, 32'hFFF0_0000: packed NUM_SLAVES×32 bits; slave i hits when (master_addr & MASK_i) == BASE_i.
- `IACK_BASE`, 32'hFFFF_FFF0: addresses ≥ IACK_BASE are interrupt-acknowledge cycles.
- `TIMEOUT`, 255: ACTIVE cycles without slave ack before bus error, 1..65535.
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `as` in 1: master address strobe, active-high.
- `master_addr` in 32: byte address.
- `master_write` in 16: write data.
- `master_uds` / `master_lds` in 1 each: byte strobes, active-high.
- `master_read` out 16: read data.
- `master_ack` out 1: cycle complete.
- `master_berr` out 1: bus error.
- `slave_read` in NUM_SLAVES×16: slice i is the read data of slave i.
- `slave_ack` in NUM_SLAVES: bit i is the acknowledge of slave i.
- `slave_write` out 16: broadcast copy of master_write.
- `slave_addr` out 32: broadcast copy of master_addr; each slave uses only its low bits.
- `slave_uds` / `slave_lds` out NUM_SLAVES each: gated strobes.
- `err_addr` out 32: master_addr of the most recent error cycle.
- `err_count` out 8: saturating count of error cycles.

## Operation
- FSM states: IDLE, ACTIVE, HOLD, ERROR.
- **IDLE**:
  - Start condition is as && (uds || lds).
  - On start, register `sel` = lowest index i that hits. Overlapping windows resolve to the lowest index.
  - Also register `iack` = (addr ≥ IACK_BASE) and `hit`.
  - If hit: go to ACTIVE and clear the timeout counter.
  - Else if iack: go to HOLD with the read latch = 16'h0000.
  - Else: go to ERROR.
- **ACTIVE**:
  - slave_uds[sel] / slave_lds[sel] = master_uds / master_lds. All other slave strobes are 0.
  - master_ack = slave_ack[sel] and master_read = slave_read[sel], both combinational.
  - On slave_ack[sel]: latch slave_read[sel] and go to HOLD.
  - Otherwise the counter increments. When the counter reaches TIMEOUT, go to ERROR.
  - If as drops (abort): go to IDLE. This is not counted as an error.
- **HOLD**:
  - All slave strobes are 0.
  - master_ack = 1 and master_read = latched data.
  - On !as: go to IDLE.
- **ERROR**:
  - master_berr = 1, master_ack = 0, master_read = 0, all slave strobes 0.
  - On entry: err_addr ← master_addr, and err_count increments, saturating at 255.
  - On !as: go to IDLE.
- In IDLE: master_ack = 0, master_berr = 0, master_read = 0, all slave strobes 0.
- slave_write and slave_addr are always direct copies of the master bus.
- Counter width is clog2(TIMEOUT+1). Counter arithmetic is unsigned.

## Timing
- Reset values: state IDLE; master_ack, master_berr, master_read, all slave strobes, err_addr and err_count all 0. Reset mid-cycle forces these values at the next edge, regardless of state.
- Decode latency: one cycle. With start at edge 0, slave strobes first appear in the cycle after edge 0.
- A slave ack in ACTIVE cycle k gives master_ack in cycle k, combinationally. master_ack then stays high through HOLD until as drops.
- Deasserting as in HOLD or ERROR returns the FSM to IDLE at the next edge; outputs are 0 from that cycle.
- Back-to-back cycles: a new start is accepted only in IDLE, so there is at least one idle cycle between bus cycles.
- Timeout: with no ack, master_berr rises in the cycle after the TIMEOUT-th ACTIVE cycle.
- An ack that arrives in the same cycle the counter reaches TIMEOUT wins: the FSM goes to HOLD with no error.
- A decode miss asserts master_berr in the cycle after the start.
- An iack cycle asserts master_ack in the cycle after the start.
- slave_ack from non-selected slaves is ignored.

## Test plan
- **RAM read:** addr 0x000010, uds=lds=1, slave_ack[0] after 3 cycles with data 0xBEEF → master_ack and master_read=0xBEEF one cycle after the start plus 3 cycles; both held until as drops; slave0 strobes drop in HOLD.
- **UART byte write:** addr 0x100004, lds only, slave_ack[1] immediate → slave_lds[1]=1 for exactly one cycle, slave_uds all 0, master_ack=1, master_berr=0.
- **Decode miss:** addr 0x200000 → master_berr=1 one cycle after the start; err_addr=0x200000; err_count=1; no slave strobe ever asserts.
- **Timeout:** TIMEOUT=4, addr 0x100100, no ack → master_berr asserts after 4 ACTIVE cycles; err_count increments; as drop returns the FSM to IDLE. Also: ack in the 4th ACTIVE cycle → master_ack, no berr.
- **Interrupt acknowledge:** addr 0xFFFFFFF6 → master_ack=1 and master_read=0x0000 in the cycle after the start, with no slave strobes; count 300 miss cycles → err_count saturates at 255.
- **Reset mid-cycle:** reset in ACTIVE → all outputs 0 at the next edge; a subsequent normal read completes correctly.

Source files
------------

// File: rtl/bus_decoder_n_if.sv
// 68000-style master bus plus the fanned-out slave bus around bus_decoder_n.
// The slave modport is the decoder's own view; the master modport is the surrounding CPU/peripheral side.
interface bus_decoder_n_if #(
    parameter int NUM_SLAVES = 6
);
    logic                       as;
    logic [31:0]                master_addr;
    logic [15:0]                master_write;
    logic                       master_uds;
    logic                       master_lds;
    logic [15:0]                master_read;
    logic                       master_ack;
    logic                       master_berr;
    logic [NUM_SLAVES*16-1:0]   slave_read;
    logic [NUM_SLAVES-1:0]      slave_ack;
    logic [15:0]                slave_write;
    logic [31:0]                slave_addr;
    logic [NUM_SLAVES-1:0]      slave_uds;
    logic [NUM_SLAVES-1:0]      slave_lds;

    // Handshake: a bus cycle starts when as && (uds || lds). The master keeps addr, data and
    // strobes stable while as is high; the decoder answers with master_ack or master_berr and
    // holds that answer until as drops. A slave completes its part by raising slave_ack.
    modport slave (
        input  as, master_addr, master_write, master_uds, master_lds, slave_read, slave_ack,
        output master_read, master_ack, master_berr, slave_write, slave_addr, slave_uds, slave_lds
    );

    modport master (
        output as, master_addr, master_write, master_uds, master_lds, slave_read, slave_ack,
        input  master_read, master_ack, master_berr, slave_write, slave_addr, slave_uds, slave_lds
    );
endinterface

// File: rtl/bus_decoder_n.sv
// Registered address decoder and read-data mux between the 68000 master bus and NUM_SLAVES slaves,
// with bus-error generation on decode misses and slave timeouts plus error address/count capture.
module bus_decoder_n #(
    parameter int                       NUM_SLAVES = 6,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = {32'h0010_0400, 32'h0010_0300, 32'h0010_0200,
                                                      32'h0010_0100, 32'h0010_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = {{5{32'hFFFF_FF00}}, 32'hFFF0_0000},
    parameter logic [31:0]              IACK_BASE  = 32'hFFFF_FFF0,
    parameter int                       TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          reset,
    bus_decoder_n_if.slave bus,
    output logic [31:0]   err_addr,
    output logic [7:0]    err_count,
    output logic [1:0]    dbg_state
);
    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_HOLD   = 2'd2,
        S_ERROR  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [SEL_W-1:0] sel_q, dec_sel;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      latch_q, latch_val, sel_read;
    logic             dec_hit, dec_iack, start, sel_ack;
    logic             load_sel, cnt_clr, cnt_inc, latch_en, err_hit;

    assign start            = bus.as && (bus.master_uds || bus.master_lds);
    assign dec_iack         = (bus.master_addr >= IACK_BASE);
    assign bus.slave_write  = bus.master_write;
    assign bus.slave_addr   = bus.master_addr;
    assign dbg_state        = state;

    // Scan downward so the lowest matching index is the one left standing.
    always_comb begin
        dec_hit = 1'b0;
        dec_sel = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((bus.master_addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
                dec_hit = 1'b1;
                dec_sel = SEL_W'(i);
            end
        end
    end

    always_comb begin
        sel_ack  = 1'b0;
        sel_read = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ack  = bus.slave_ack[i];
                sel_read = bus.slave_read[i*16 +: 16];
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        load_sel        = 1'b0;
        cnt_clr         = 1'b0;
        cnt_inc         = 1'b0;
        latch_en        = 1'b0;
        latch_val       = '0;
        err_hit         = 1'b0;
        bus.master_ack  = 1'b0;
        bus.master_berr = 1'b0;
        bus.master_read = '0;
        bus.slave_uds   = '0;
        bus.slave_lds   = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load_sel = 1'b1;
                    if (dec_hit) begin
                        state_nxt = S_ACTIVE;
                        cnt_clr   = 1'b1;
                    end else if (dec_iack) begin
                        state_nxt = S_HOLD;
                        latch_en  = 1'b1;
                    end else begin
                        state_nxt = S_ERROR;
                        err_hit   = 1'b1;
                    end
                end
            end
            S_ACTIVE: begin
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    bus.slave_uds[i] = bus.master_uds && (sel_q == SEL_W'(i));
                    bus.slave_lds[i] = bus.master_lds && (sel_q == SEL_W'(i));
                end
                bus.master_ack  = sel_ack;
                bus.master_read = sel_read;
                // An abort beats everything; an ack beats a timeout landing in the same cycle.
                if (!bus.as) begin
                    state_nxt = S_IDLE;
                end else if (sel_ack) begin
                    state_nxt = S_HOLD;
                    latch_en  = 1'b1;
                    latch_val = sel_read;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_nxt = S_ERROR;
                    err_hit   = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_HOLD: begin
                bus.master_ack  = 1'b1;
                bus.master_read = latch_q;
                if (!bus.as) state_nxt = S_IDLE;
            end
            S_ERROR: begin
                bus.master_berr = 1'b1;
                if (!bus.as) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            latch_q   <= '0;
            err_addr  <= '0;
            err_count <= '0;
        end else begin
            state <= state_nxt;
            if (load_sel) sel_q <= dec_sel;
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (latch_en) latch_q <= latch_val;
            if (err_hit) begin
                err_addr <= bus.master_addr;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_bus_decoder_n.sv
// Self-checking bench for bus_decoder_n: scripted and random bus cycles, each cycle's outputs
// derived from the decode rules and pushed to an expected queue that a negedge process drains.
module tb_bus_decoder_n;
    localparam int NS  = 6;
    localparam int TMO = 4;

    typedef struct packed {
        logic          ack;
        logic          berr;
        logic [15:0]   read;
        logic [NS-1:0] uds;
        logic [NS-1:0] lds;
        logic [31:0]   err_addr;
        logic [7:0]    err_count;
        logic [31:0]   addr;
        logic [15:0]   wdata;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic              clk;
    logic              reset;
    logic [31:0]       err_addr;
    logic [7:0]        err_count;
    logic [1:0]        dbg_state;
    logic [EXP_W-1:0]  exp_q[$];

    logic [31:0]       m_base [NS];
    logic [31:0]       m_mask [NS];
    logic [31:0]       m_err_addr;
    int                m_err_count;
    int                n_checks;
    int                n_pass;

    bus_decoder_n_if #(.NUM_SLAVES(NS)) bus ();

    bus_decoder_n #(
        .NUM_SLAVES(NS),
        .TIMEOUT   (TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .err_addr (err_addr),
        .err_count(err_count),
        .dbg_state(dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Address map as software sees it: first window in index order wins.
    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & m_mask[i]) == m_base[i]) return i;
        end
        return -1;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_slaves(input int tgt, input logic ack_val);
        for (int i = 0; i < NS; i++) bus.slave_read[i*16 +: 16] = 16'($urandom);
        bus.slave_ack = NS'($urandom);
        if (tgt >= 0) bus.slave_ack[tgt] = ack_val;
    endtask

    task automatic push_exp(input logic ack, input logic berr, input logic [15:0] rd,
                            input logic [NS-1:0] su, input logic [NS-1:0] sl);
        exp_t e;
        e.ack       = ack;
        e.berr      = berr;
        e.read      = rd;
        e.uds       = su;
        e.lds       = sl;
        e.err_addr  = m_err_addr;
        e.err_count = 8'(m_err_count);
        e.addr      = bus.master_addr;
        e.wdata     = bus.master_write;
        exp_q.push_back(EXP_W'(e));
    endtask

    task automatic idle_cycle();
        next_cycle();
        bus.as           = 1'($urandom);
        bus.master_addr  = $urandom;
        bus.master_write = 16'($urandom);
        bus.master_uds   = bus.as ? 1'b0 : 1'($urandom);
        bus.master_lds   = bus.as ? 1'b0 : 1'($urandom);
        rand_slaves(-1, 1'b0);
        push_exp(1'b0, 1'b0, 16'h0, '0, '0);
    endtask

    // One master bus cycle. ack_at: ACTIVE cycle (1-based) of the slave ack, 0 = never;
    // abort_at: ACTIVE cycle where as drops; hold_n: cycles as stays high after ack/berr.
    task automatic bus_cycle(input logic [31:0] addr, input logic uds, input logic lds,
                             input int ack_at, input int abort_at, input int hold_n, input int data);
        int            tgt;
        logic          to_hold;
        logic          to_err;
        logic          ackd;
        logic [15:0]   held;
        logic [NS-1:0] su;
        logic [NS-1:0] sl;
        tgt     = decode(addr);
        to_hold = 1'b0;
        to_err  = 1'b0;
        held    = 16'h0;
        next_cycle();
        bus.as           = 1'b1;
        bus.master_addr  = addr;
        bus.master_uds   = uds;
        bus.master_lds   = lds;
        bus.master_write = 16'($urandom);
        rand_slaves(-1, 1'b0);
        push_exp(1'b0, 1'b0, 16'h0, '0, '0);
        if (tgt >= 0) begin
            su = uds ? (NS'(1) << tgt) : '0;
            sl = lds ? (NS'(1) << tgt) : '0;
            for (int j = 1; j <= TMO; j++) begin
                next_cycle();
                ackd = (j == ack_at) && (j != abort_at);
                rand_slaves(tgt, ackd);
                if (ackd && data >= 0) bus.slave_read[tgt*16 +: 16] = 16'(data);
                if (j == abort_at) bus.as = 1'b0;
                push_exp(ackd, 1'b0, bus.slave_read[tgt*16 +: 16], su, sl);
                if (j == abort_at) break;
                if (ackd) begin
                    to_hold = 1'b1;
                    held    = bus.slave_read[tgt*16 +: 16];
                    break;
                end
                if (j == TMO) to_err = 1'b1;
            end
        end else if (addr >= 32'hFFFF_FFF0) begin
            to_hold = 1'b1;
        end else begin
            to_err = 1'b1;
        end
        if (to_err) begin
            m_err_addr = addr;
            if (m_err_count < 255) m_err_count++;
        end
        if (to_hold || to_err) begin
            for (int h = 0; h <= hold_n; h++) begin
                next_cycle();
                rand_slaves(-1, 1'b0);
                if (h == hold_n) bus.as = 1'b0;
                push_exp(to_hold, to_err, to_hold ? held : 16'h0, '0, '0);
            end
        end
        idle_cycle();
    endtask

    task automatic reset_mid();
        next_cycle();
        bus.as          = 1'b1;
        bus.master_addr = 32'h0010_0104;
        bus.master_uds  = 1'b1;
        bus.master_lds  = 1'b1;
        rand_slaves(-1, 1'b0);
        push_exp(1'b0, 1'b0, 16'h0, '0, '0);
        for (int j = 1; j <= 2; j++) begin
            next_cycle();
            rand_slaves(2, 1'b0);
            if (j == 2) reset = 1'b1;
            push_exp(1'b0, 1'b0, bus.slave_read[2*16 +: 16], NS'(1) << 2, NS'(1) << 2);
        end
        m_err_addr  = '0;
        m_err_count = 0;
        next_cycle();
        reset  = 1'b0;
        bus.as = 1'b0;
        rand_slaves(-1, 1'b0);
        push_exp(1'b0, 1'b0, 16'h0, '0, '0);
    endtask

    // Scoreboard
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_t'(exp_q.pop_front());
            chk("master_ack",  32'(bus.master_ack),  32'(e.ack));
            chk("master_berr", 32'(bus.master_berr), 32'(e.berr));
            chk("master_read", 32'(bus.master_read), 32'(e.read));
            chk("slave_uds",   32'(bus.slave_uds),   32'(e.uds));
            chk("slave_lds",   32'(bus.slave_lds),   32'(e.lds));
            chk("err_addr",    err_addr,             e.err_addr);
            chk("err_count",   32'(err_count),       32'(e.err_count));
            chk("slave_addr",  bus.slave_addr,       e.addr);
            chk("slave_write", 32'(bus.slave_write), 32'(e.wdata));
        end
    end

    // Stimulus
    initial begin
        logic [31:0] addr;
        logic [1:0]  strb;
        int          r;
        int          s;
        m_base = '{32'h0000_0000, 32'h0010_0000, 32'h0010_0100, 32'h0010_0200, 32'h0010_0300, 32'h0010_0400};
        m_mask = '{32'hFFF0_0000, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00};
        m_err_addr       = '0;
        m_err_count      = 0;
        n_checks         = 0;
        n_pass           = 0;
        reset            = 1'b1;
        bus.as           = 1'b0;
        bus.master_addr  = '0;
        bus.master_write = '0;
        bus.master_uds   = 1'b0;
        bus.master_lds   = 1'b0;
        bus.slave_read   = '0;
        bus.slave_ack    = '0;

        repeat (2) @(posedge clk);
        #1;
        push_exp(1'b0, 1'b0, 16'h0, '0, '0);
        #3;
        chk("reset_dbg_idle", 32'(dbg_state), 32'd0);
        next_cycle();
        reset = 1'b0;
        push_exp(1'b0, 1'b0, 16'h0, '0, '0);

        chk("map_ram",   32'(decode(32'h0000_0010)), 32'd0);
        chk("map_uart",  32'(decode(32'h0010_0004)), 32'd1);
        chk("map_intc",  32'(decode(32'h0010_04FF)), 32'd5);
        chk("map_miss",  32'(decode(32'h0020_0000)), 32'hFFFF_FFFF);

        bus_cycle(32'h0000_0010, 1'b1, 1'b1, 4, 0, 2, 16'hBEEF);
        bus_cycle(32'h0010_0004, 1'b0, 1'b1, 1, 0, 1, -1);
        bus_cycle(32'h0020_0000, 1'b1, 1'b1, 0, 0, 2, -1);
        #3;
        chk("miss_err_addr",  err_addr, 32'h0020_0000);
        chk("miss_err_count", 32'(err_count), 32'd1);
        bus_cycle(32'h0010_0100, 1'b1, 1'b0, 0, 0, 1, -1);
        #3;
        chk("timeout_err_count", 32'(err_count), 32'd2);
        bus_cycle(32'h0010_0100, 1'b1, 1'b1, 4, 0, 0, -1);
        bus_cycle(32'h0010_0200, 1'b1, 1'b1, 0, 2, 0, -1);
        bus_cycle(32'hFFFF_FFF6, 1'b1, 1'b1, 0, 0, 1, -1);
        bus_cycle(32'hFFFF_FFEF, 1'b0, 1'b1, 0, 0, 0, -1);
        reset_mid();
        bus_cycle(32'h0000_0020, 1'b1, 1'b1, 2, 0, 1, -1);

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                s    = $urandom_range(0, NS - 1);
                addr = m_base[s] | ((s == 0) ? 32'($urandom_range(0, 32'h000F_FFFF))
                                             : 32'($urandom_range(0, 255)));
            end else if (r < 8) begin
                addr = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            end else begin
                addr = 32'h0020_0000 | 32'($urandom_range(0, 32'h0000_FFFF));
            end
            strb = 2'($urandom_range(1, 3));
            bus_cycle(addr, strb[1], strb[0], $urandom_range(1, 6),
                      ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : 0,
                      $urandom_range(0, 3), -1);
        end

        for (int n = 0; n < 300; n++) begin
            bus_cycle(32'h0030_0000 | 32'($urandom_range(0, 32'h0000_FFFF)), 1'b1, 1'b1, 0, 0, 0, -1);
        end
        #3;
        chk("err_count_saturated", 32'(err_count), 32'd255);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
